// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM design: breath sequencer states,
// the bus widths agreed with the PWM generator, and ms-prescaler sizing.
package led_pwm_pkg;

    localparam int unsigned DUTY_W = 10;
    localparam int unsigned RATE_W = 21;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RISE   = 3'd1,
        TOP    = 3'd2,
        FALL   = 3'd3,
        BOTTOM = 3'd4
    } breath_state_t;

    // Number of system-clock cycles in one millisecond for a clock in MHz.
    function automatic int unsigned cycles_per_ms(input int unsigned clk_fre);
        return clk_fre * 1000;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler.
//   clk, rst_n : system clock, async active-low reset
//   clr        : synchronous clear, holds the prescaler at 0
//   tick       : registered, high for the terminal-count cycle of each ms
module ms_tick_gen #(
    parameter int unsigned CYC_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(CYC_PER_MS - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = (cnt == TC) ? '0 : cnt + CNT_W'(1);
    end

    // tick is registered from the next count so it is high exactly while cnt == TC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == TC);
        end
    end

endmodule

// File: rtl/breath_duty_gen.sv
// Breathing-LED duty sequencer feeding the PWM generator.
// Ramps duty 0 -> DUTY_MAX -> 0 with step_ms ms per 1% step and HOLD_MS ms
// holds at the top and bottom.
//   clk, rst_n : system clock, async active-low reset
//   en         : level enable, low returns to IDLE
//   step_ms    : ms per duty step (0 treated as 1)
//   pwm_duty   : registered duty 0..DUTY_MAX
//   pwm_rate   : constant PWM_RATE
//   phase      : current state encoding
//   cycle_done : one-cycle pulse when a full breath completes
module breath_duty_gen
    import led_pwm_pkg::*;
#(
    parameter int unsigned CLK_FRE  = 50,
    parameter int unsigned PWM_RATE = 1000,
    parameter int unsigned DUTY_MAX = 100,
    parameter int unsigned HOLD_MS  = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [7:0]        step_ms,
    output logic [DUTY_W-1:0] pwm_duty,
    output logic [RATE_W-1:0] pwm_rate,
    output logic [2:0]        phase,
    output logic              cycle_done
);

    localparam int unsigned HOLD_W = (HOLD_MS > 1) ? $clog2(HOLD_MS + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);
    localparam logic [DUTY_W-1:0] DUTY_TOP  = DUTY_W'(DUTY_MAX);

    breath_state_t     state, state_n;
    logic [DUTY_W-1:0] duty, duty_n;
    logic [7:0]        step_cnt, step_n;
    logic [7:0]        step_lat, lat_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              done, done_n;

    logic              tick;
    logic              presc_clr;
    logic [7:0]        step_ms_eff;
    logic              step_exp;
    logic              hold_exp;
    logic [DUTY_W-1:0] duty_inc;
    logic [DUTY_W-1:0] duty_dec;

    assign presc_clr = !en || (state == IDLE);

    ms_tick_gen #(
        .CYC_PER_MS(cycles_per_ms(CLK_FRE))
    ) u_ms_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (presc_clr),
        .tick (tick)
    );

    // Step/hold expiry and duty neighbours
    always_comb begin
        step_ms_eff = (step_ms == 8'd0) ? 8'd1 : step_ms;
        step_exp    = tick && (step_cnt == (step_lat - 8'd1));
        hold_exp    = tick && (hold_cnt == HOLD_LAST);
        duty_inc    = duty + DUTY_W'(1);
        duty_dec    = duty - DUTY_W'(1);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty     <= '0;
            step_cnt <= '0;
            step_lat <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            duty     <= duty_n;
            step_cnt <= step_n;
            step_lat <= lat_n;
            hold_cnt <= hold_n;
            done     <= done_n;
        end
    end

    // Next state and datapath; bounds are reached on the same edge as the
    // state change so duty can never wrap
    always_comb begin
        state_n = state;
        duty_n  = duty;
        step_n  = step_cnt;
        lat_n   = step_lat;
        hold_n  = hold_cnt;
        done_n  = 1'b0;

        if (!en) begin
            state_n = IDLE;
            duty_n  = '0;
            step_n  = '0;
            lat_n   = '0;
            hold_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = RISE;
                    duty_n  = '0;
                    step_n  = '0;
                    hold_n  = '0;
                    lat_n   = step_ms_eff;
                end
                RISE: begin
                    if (step_exp) begin
                        step_n = '0;
                        lat_n  = step_ms_eff;
                        duty_n = duty_inc;
                        if (duty_inc == DUTY_TOP) begin
                            state_n = TOP;
                        end
                    end else if (tick) begin
                        step_n = step_cnt + 8'd1;
                    end
                end
                TOP: begin
                    if (hold_exp) begin
                        hold_n  = '0;
                        state_n = FALL;
                    end else if (tick) begin
                        hold_n = hold_cnt + HOLD_W'(1);
                    end
                end
                FALL: begin
                    if (step_exp) begin
                        step_n = '0;
                        lat_n  = step_ms_eff;
                        duty_n = duty_dec;
                        if (duty_dec == '0) begin
                            state_n = BOTTOM;
                        end
                    end else if (tick) begin
                        step_n = step_cnt + 8'd1;
                    end
                end
                BOTTOM: begin
                    if (hold_exp) begin
                        hold_n  = '0;
                        state_n = RISE;
                        done_n  = 1'b1;
                    end else if (tick) begin
                        hold_n = hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    duty_n  = '0;
                    step_n  = '0;
                    lat_n   = '0;
                    hold_n  = '0;
                end
            endcase
        end
    end

    assign pwm_duty   = duty;
    assign pwm_rate   = RATE_W'(PWM_RATE);
    assign phase      = state;
    assign cycle_done = done;

endmodule

// File: doc/breath_duty_gen.md
# breath_duty_gen

Breathing-LED duty sequencer that sits directly upstream of the PWM generator in the LED PWM design. It drives that stage's `pwm_duty` (0–100 %) and `pwm_rate` inputs. It ramps duty linearly 0→100→0 with programmable step time and fixed holds at the top and bottom, so the downstream PWM output fades smoothly. All timing is derived from a millisecond tick generated from the system clock.

## Interface
Parameters:
- `CLK_FRE`, 50: system clock in MHz; one ms = `CLK_FRE*1000` cycles.
- `PWM_RATE`, 1000: PWM frequency in Hz presented on `pwm_rate`; legal range 1..500000.
- `DUTY_MAX`, 100: top duty value, ≤100.
- `HOLD_MS`, 200: hold time at top and bottom, in ms, ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  level enable; low forces IDLE.
- `step_ms`  in  8  ms per 1 % duty step; 0 is treated as 1.
- `pwm_duty`  out  10  registered duty 0..`DUTY_MAX`, feeds the PWM generator.
- `pwm_rate`  out  21  constant `PWM_RATE`, feeds the PWM generator.
- `phase`  out  3  current state encoding.
- `cycle_done`  out  1  one-cycle pulse at the end of each full breath.

## Operation
- Ms prescaler counts 0..`CLK_FRE*1000-1` only while `en`=1 and the state is not IDLE. `tick`=1 in the terminal-count cycle, then the prescaler wraps to 0.
- Step counter counts ticks. A step expires on a `tick` with step count = `step_lat-1`. On expiry the counter clears.
- `step_lat` is loaded from `step_ms` (0→1) on IDLE exit and on every step expiry. A mid-step change to `step_ms` therefore applies from the next step.
- Hold counter counts ticks to `HOLD_MS`.
- States:
  - **IDLE**: duty 0, all counters 0. When `en`=1, go to RISE on the next edge.
  - **RISE**: each step expiry increments `pwm_duty`. The expiry that writes `DUTY_MAX` also moves the state to TOP.
  - **TOP**: `pwm_duty`=`DUTY_MAX`. After `HOLD_MS` ticks, go to FALL.
  - **FALL**: each step expiry decrements `pwm_duty`. The expiry that writes 0 also moves the state to BOTTOM.
  - **BOTTOM**: `pwm_duty`=0. After `HOLD_MS` ticks, go to RISE and assert `cycle_done` for that single cycle.
- `en`=0 in any state: on the next edge go to IDLE, `pwm_duty`=0, all counters cleared, no `cycle_done`. Re-enabling restarts from duty 0 in RISE.
- Arithmetic: duty never leaves 0..`DUTY_MAX`. No wrap is possible, because the state changes on the same edge that reaches a bound.
- Sizing: the prescaler must hold `CLK_FRE*1000-1`; 17 bits for `CLK_FRE`≤100. Step counter is 8 bits. Hold counter is sized by `$clog2(HOLD_MS+1)`.

## Timing
- Reset values: `pwm_duty`=0, `phase`=IDLE(0), `cycle_done`=0. All counters are 0. `pwm_rate` is constant and never changes, including during reset.
- Latency: `pwm_duty` updates on the edge that samples the expiring tick; it is registered, with no combinational path from `en` or `step_ms`.
- Step period is exactly `step_lat*CLK_FRE*1000` cycles.
- One breath lasts `2*DUTY_MAX*step_ms + 2*HOLD_MS` ms. The IDLE→RISE transition adds 1 cycle.
- `en` deassert is seen at the next edge, and the effect is visible 1 cycle after.
- Async reset mid-ramp clears everything immediately. Release is synchronous to the next `clk` edge.
- The downstream PWM stage samples `pwm_duty` continuously. Duty changes at most once per ms, and the glitch-free duty update at the PWM period boundary is the downstream stage's responsibility.

## Structure
- Shared package `led_pwm_pkg`:
  - state enum: IDLE=0, RISE=1, TOP=2, FALL=3, BOTTOM=4.
  - `DUTY_W`=10 and `RATE_W`=21, shared with the PWM generator.
  - a function computing cycles-per-ms from `CLK_FRE`.
- Sub-module `ms_tick_gen`: prescaler with `clk`, `rst_n` and a synchronous clear input, producing `tick`.
- The top level holds the FSM, the step and hold counters, and the duty register.

## Test plan
Run with `CLK_FRE`=1 (1000 cycles/ms), `HOLD_MS`=2, `DUTY_MAX`=100 unless noted.
- Reset, then `en`=1 with `step_ms`=1: `pwm_duty` goes 0→1 exactly 1000 cycles after RISE entry and reaches 100 at 100000 cycles. `phase`=TOP on that same edge.
- Continue the first scenario: TOP lasts 2000 cycles, then duty decrements every 1000 cycles to 0. After 2000 cycles in BOTTOM, `cycle_done` pulses for exactly 1 cycle and `phase`=RISE. `pwm_rate` reads 1000 throughout.
- `step_ms`=0: behaves identically to `step_ms`=1. Changing `step_ms` from 1 to 3 mid-step: the current step completes at 1000 cycles and the next step takes 3000.
- Drop `en` at duty 57 in FALL: the next edge gives `phase`=IDLE and duty 0 with no `cycle_done`. Re-assert `en`: ramp restarts from 0.
- Assert `rst_n`=0 asynchronously mid-RISE, between clock edges: outputs go to 0/IDLE immediately without waiting for a clock edge. After release, operation resumes from IDLE.
- `DUTY_MAX`=50: duty peaks at 50 and never exceeds it; the breath period equals `2*50*step_ms+4` ms.
